// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32IM DIV/DIVU/REM/REMU.
// Works on operand magnitudes for WIDTH cycles, then applies signs in a single fix-up cycle.
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             START,
   input  logic [1:0]       FUNC,
   input  logic [WIDTH-1:0] DIVIDEND,
   input  logic [WIDTH-1:0] DIVISOR,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] RESULT
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      FIN
   } state_e;

   function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
      return (~x) + ONE;
   endfunction

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   quo_q, quo_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   dvs_q, dvs_d;
   logic               op_rem_q, op_rem_d;
   logic               sgn_q, sgn_d;
   logic               q_neg_q, q_neg_d;
   logic               r_neg_q, r_neg_d;
   logic               special_q, special_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   result_q, result_d;

   logic               cap_sgn;
   logic [WIDTH-1:0]   cap_a_mag;
   logic [WIDTH-1:0]   cap_b_mag;
   logic [WIDTH:0]     rem_shift;
   logic               take;
   logic [WIDTH-1:0]   q_fix;
   logic [WIDTH-1:0]   r_fix;

   // Capture-side operand conditioning, shared by IDLE and FIN.
   assign cap_sgn   = ~FUNC[0];
   assign cap_a_mag = (cap_sgn && DIVIDEND[WIDTH-1]) ? negate(DIVIDEND) : DIVIDEND;
   assign cap_b_mag = (cap_sgn && DIVISOR[WIDTH-1])  ? negate(DIVISOR)  : DIVISOR;

   // The partial remainder keeps the bit shifted out of its MSB so large unsigned
   // divisors (>= 2^(WIDTH-1)) still compare correctly.
   assign rem_shift = {rem_q, quo_q[WIDTH-1]};
   assign take      = (rem_shift >= {1'b0, dvs_q});

   assign q_fix = (sgn_q && q_neg_q && !special_q) ? negate(quo_q) : quo_q;
   assign r_fix = (sgn_q && r_neg_q && !special_q) ? negate(rem_q) : rem_q;

   // NOTE: every output of this block gets a default first so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      dvs_d     = dvs_q;
      op_rem_d  = op_rem_q;
      sgn_d     = sgn_q;
      q_neg_d   = q_neg_q;
      r_neg_d   = r_neg_q;
      special_d = special_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      result_d  = result_q;

      unique case (state_q)
         IDLE, FIN: begin
            state_d = IDLE;
            if (START) begin
               op_rem_d = FUNC[1];
               sgn_d    = cap_sgn;
               q_neg_d  = DIVIDEND[WIDTH-1] ^ DIVISOR[WIDTH-1];
               r_neg_d  = DIVIDEND[WIDTH-1];
               dvs_d    = cap_b_mag;
               cnt_d    = CNT_W'(WIDTH);
               busy_d   = 1'b1;
               if (DIVISOR == '0) begin
                  special_d = 1'b1;
                  quo_d     = '1;
                  rem_d     = DIVIDEND;
                  state_d   = FIX;
               end else if (cap_sgn && DIVIDEND == MIN_NEG && DIVISOR == '1) begin
                  special_d = 1'b1;
                  quo_d     = MIN_NEG;
                  rem_d     = '0;
                  state_d   = FIX;
               end else begin
                  special_d = 1'b0;
                  quo_d     = cap_a_mag;
                  rem_d     = '0;
                  state_d   = CALC;
               end
            end
         end

         CALC: begin
            quo_d = {quo_q[WIDTH-2:0], take};
            rem_d = take ? (rem_shift[WIDTH-1:0] - dvs_q) : rem_shift[WIDTH-1:0];
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = FIX;
            end
         end

         FIX: begin
            result_d = op_rem_q ? r_fix : q_fix;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = FIN;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         quo_q     <= '0;
         rem_q     <= '0;
         dvs_q     <= '0;
         op_rem_q  <= 1'b0;
         sgn_q     <= 1'b0;
         q_neg_q   <= 1'b0;
         r_neg_q   <= 1'b0;
         special_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         quo_q     <= quo_d;
         rem_q     <= rem_d;
         dvs_q     <= dvs_d;
         op_rem_q  <= op_rem_d;
         sgn_q     <= sgn_d;
         q_neg_q   <= q_neg_d;
         r_neg_q   <= r_neg_d;
         special_q <= special_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         result_q  <= result_d;
      end
   end

   assign BUSY   = busy_q;
   assign DONE   = done_q;
   assign RESULT = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, busy/done framing, signed fix-up,
// special cases, back-to-back issue from FIN and asynchronous abort.
module tb_div_unit;

   logic        CLK;
   logic        RESET_N;
   logic        START;
   logic [1:0]  FUNC;
   logic [31:0] DIVIDEND;
   logic [31:0] DIVISOR;
   logic        BUSY;
   logic        DONE;
   logic [31:0] RESULT;

   int          n_pass;
   int          n_fail;
   int          n_total;
   logic [31:0] last_result;
   int          done_seen;

   div_unit #(.WIDTH(32)) dut (
      .CLK      (CLK),
      .RESET_N  (RESET_N),
      .START    (START),
      .FUNC     (FUNC),
      .DIVIDEND (DIVIDEND),
      .DIVISOR  (DIVISOR),
      .BUSY     (BUSY),
      .DONE     (DONE),
      .RESULT   (RESULT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Call at a falling edge; returns at the falling edge inside the DONE cycle.
   task automatic run_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int exp_lat, input string tag);
      int done_edge;
      int busy_cnt;
      done_edge = -1;
      busy_cnt  = 0;
      START     = 1'b1;
      FUNC      = f;
      DIVIDEND  = a;
      DIVISOR   = b;
      @(posedge CLK);
      @(negedge CLK);
      START    = 1'b0;
      FUNC     = ~f;
      DIVIDEND = 32'hDEAD_BEEF;
      DIVISOR  = 32'h0000_0001;
      check({tag, "/busy_after_start"}, {31'd0, BUSY}, 32'd1);
      check({tag, "/done_after_start"}, {31'd0, DONE}, 32'd0);
      check({tag, "/result_held"}, RESULT, last_result);
      for (int k = 1; k <= 40; k++) begin
         @(posedge CLK);
         @(negedge CLK);
         START = 1'b0;
         if (DONE) begin
            done_edge = k;
            break;
         end
         if (BUSY) busy_cnt++;
         if (k == 4 && exp_lat > 5) begin
            START    = 1'b1;
            FUNC     = 2'b01;
            DIVIDEND = 32'd100;
            DIVISOR  = 32'd7;
         end
      end
      check({tag, "/done_edge"}, done_edge, exp_lat);
      check({tag, "/result"}, RESULT, exp);
      check({tag, "/busy_at_done"}, {31'd0, BUSY}, 32'd0);
      check({tag, "/busy_cycles"}, busy_cnt, exp_lat - 1);
      last_result = exp;
   endtask

   task automatic idle_cycle();
      @(posedge CLK);
      @(negedge CLK);
      check("idle/done_low", {31'd0, DONE}, 32'd0);
   endtask

   initial begin
      n_pass      = 0;
      n_fail      = 0;
      n_total     = 0;
      last_result = 32'd0;
      RESET_N     = 1'b0;
      START       = 1'b0;
      FUNC        = 2'b00;
      DIVIDEND    = 32'd0;
      DIVISOR     = 32'd0;

      #12;
      check("reset/busy", {31'd0, BUSY}, 32'd0);
      check("reset/done", {31'd0, DONE}, 32'd0);
      check("reset/result", RESULT, 32'd0);
      @(negedge CLK);
      RESET_N = 1'b1;
      @(negedge CLK);

      run_op(2'b00, 32'd20, 32'd3, 32'd6, 33, "div_20_3");
      idle_cycle();
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem_m7_2");
      run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div_m7_2");
      run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 32'd1, 33, "remu_fff9_2");
      idle_cycle();
      run_op(2'b01, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 33, "divu_ffff_2");
      run_op(2'b00, 32'hFFFF_FFFF, 32'd2, 32'd0, 33, "div_m1_2");
      run_op(2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, "div_7_m2");
      run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, "rem_7_m2");
      idle_cycle();

      run_op(2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "div_5_0");
      run_op(2'b10, 32'd5, 32'd0, 32'd5, 1, "rem_5_0");
      run_op(2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1, "rem_m5_0");
      run_op(2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divu_5_0");
      idle_cycle();
      run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf");
      run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, "divu_min_max");
      run_op(2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 33, "divu_big");
      run_op(2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 33, "remu_big");
      idle_cycle();

      // Abort a DIV at edge 10 with an asynchronous reset.
      START    = 1'b1;
      FUNC     = 2'b00;
      DIVIDEND = 32'd1000;
      DIVISOR  = 32'd3;
      @(posedge CLK);
      @(negedge CLK);
      START = 1'b0;
      repeat (10) @(posedge CLK);
      #2;
      RESET_N = 1'b0;
      #1;
      check("abort/busy", {31'd0, BUSY}, 32'd0);
      check("abort/done", {31'd0, DONE}, 32'd0);
      check("abort/result", RESULT, 32'd0);
      @(negedge CLK);
      @(negedge CLK);
      RESET_N   = 1'b1;
      done_seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge CLK);
         if (DONE) done_seen++;
      end
      check("abort/no_done", done_seen, 0);
      check("abort/busy_idle", {31'd0, BUSY}, 32'd0);
      last_result = 32'd0;
      run_op(2'b01, 32'd100, 32'd7, 32'd14, 33, "divu_100_7");
      idle_cycle();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
